// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS control path.
package mips_defs;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALUOP_W   = 4;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned PCSRC_W   = 2;
    localparam int unsigned INSTRET_W = 32;

    // Opcode field values
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BLTZ  = 6'b000001;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    // R-type funct field values
    localparam logic [FUNCT_W-1:0] F_SLL = 6'b000000;
    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    // Next-PC source select
    localparam logic [PCSRC_W-1:0] PCSRC_SEQ = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_BR  = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JMP = 2'b10;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLL = 4'd4,
        ALU_SLT = 4'd5
    } alu_op_e;

    // Codes 6 and 7 are unused and recover to S_HALT
    typedef enum logic [STATE_W-1:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        IC_RTYPE,
        IC_IALU,
        IC_LW,
        IC_SW,
        IC_BEQ,
        IC_BNE,
        IC_BLTZ,
        IC_J,
        IC_HALT,
        IC_ILLEGAL
    } inst_class_e;

    // Datapath controls fixed for the whole instruction once decoded
    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src_a;
        logic    alu_src_b;
        logic    ext_sel;
        logic    reg_dst;
    } dec_ctrl_t;

endpackage

// File: rtl/inst_decode.sv
// Combinational opcode/funct decoder: instruction class plus static datapath controls.
module inst_decode
    import mips_defs::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output inst_class_e        iclass,
    output dec_ctrl_t          ctrl
);

    // Classify the instruction and derive its ALU operation and operand selects
    always_comb begin
        iclass         = IC_ILLEGAL;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = 1'b0;
        ctrl.ext_sel   = 1'b1;
        ctrl.reg_dst   = 1'b0;
        case (op)
            OP_RTYPE: begin
                iclass       = IC_RTYPE;
                ctrl.reg_dst = 1'b1;
                case (funct)
                    F_ADD: ctrl.alu_op = ALU_ADD;
                    F_SUB: ctrl.alu_op = ALU_SUB;
                    F_AND: ctrl.alu_op = ALU_AND;
                    F_OR:  ctrl.alu_op = ALU_OR;
                    F_SLT: ctrl.alu_op = ALU_SLT;
                    F_SLL: begin
                        ctrl.alu_op    = ALU_SLL;
                        ctrl.alu_src_a = 1'b1;
                    end
                    default: begin
                        iclass       = IC_ILLEGAL;
                        ctrl.reg_dst = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                iclass         = IC_IALU;
                ctrl.alu_src_b = 1'b1;
            end
            OP_ANDI: begin
                iclass         = IC_IALU;
                ctrl.alu_op    = ALU_AND;
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sel   = 1'b0;
            end
            OP_ORI: begin
                iclass         = IC_IALU;
                ctrl.alu_op    = ALU_OR;
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sel   = 1'b0;
            end
            OP_SLTI: begin
                iclass         = IC_IALU;
                ctrl.alu_op    = ALU_SLT;
                ctrl.alu_src_b = 1'b1;
            end
            OP_LW: begin
                iclass         = IC_LW;
                ctrl.alu_src_b = 1'b1;
            end
            OP_SW: begin
                iclass         = IC_SW;
                ctrl.alu_src_b = 1'b1;
            end
            OP_BEQ: begin
                iclass      = IC_BEQ;
                ctrl.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                iclass      = IC_BNE;
                ctrl.alu_op = ALU_SUB;
            end
            OP_BLTZ: begin
                iclass      = IC_BLTZ;
                ctrl.alu_op = ALU_SUB;
            end
            OP_J:    iclass = IC_J;
            OP_HALT: iclass = IC_HALT;
            default: iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with sticky stop flags and retired-instruction counter.
module multicycle_control
    import mips_defs::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    input  logic                 sign,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 Regwrite,
    output logic                 mWR,
    output logic                 ALUsrcA,
    output logic                 ALUsrcB,
    output logic                 RegDst,
    output logic                 ExtSel,
    output logic                 datasrc,
    output logic [PCSRC_W-1:0]   pcsrc,
    output logic [ALUOP_W-1:0]   ALUop,
    output logic [STATE_W-1:0]   state,
    output logic                 halt,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    state_e                 state_q;
    state_e                 state_n;
    inst_class_e            iclass;
    dec_ctrl_t              ctrl;
    logic                   halt_q;
    logic                   illegal_q;
    logic [INSTRET_W-1:0]   instret_q;
    logic                   pc_write;
    logic                   ir_write;
    logic                   reg_write;
    logic                   m_wr;
    logic                   reg_dst;
    logic                   data_src;
    logic                   sel_en;
    logic                   set_halt;
    logic                   set_illegal;
    logic [PCSRC_W-1:0]     pc_src;

    inst_decode u_decode (
        .op     (op),
        .funct  (funct),
        .iclass (iclass),
        .ctrl   (ctrl)
    );

    // State, sticky flags and retire counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_n;
            if (set_halt)    halt_q    <= 1'b1;
            if (set_illegal) illegal_q <= 1'b1;
            if (pc_write)    instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    // Next-state and per-state enables; PC is written only in an instruction's last state
    always_comb begin
        state_n     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        m_wr        = 1'b0;
        reg_dst     = 1'b0;
        data_src    = 1'b0;
        sel_en      = 1'b0;
        set_halt    = 1'b0;
        set_illegal = 1'b0;
        pc_src      = PCSRC_SEQ;
        case (state_q)
            S_IF: begin
                ir_write = 1'b1;
                state_n  = S_ID;
            end
            S_ID: begin
                sel_en = 1'b1;
                case (iclass)
                    IC_J: begin
                        pc_write = 1'b1;
                        pc_src   = PCSRC_JMP;
                        state_n  = S_IF;
                    end
                    IC_HALT: begin
                        set_halt = 1'b1;
                        state_n  = S_HALT;
                    end
                    IC_ILLEGAL: begin
                        set_illegal = 1'b1;
                        state_n     = S_HALT;
                    end
                    default: state_n = S_EXE;
                endcase
            end
            S_EXE: begin
                sel_en = 1'b1;
                case (iclass)
                    IC_LW, IC_SW:     state_n = S_MEM;
                    IC_RTYPE, IC_IALU: state_n = S_WB;
                    IC_BEQ, IC_BNE, IC_BLTZ: begin
                        pc_write = 1'b1;
                        state_n  = S_IF;
                        if ((iclass == IC_BEQ  &&  zero) ||
                            (iclass == IC_BNE  && !zero) ||
                            (iclass == IC_BLTZ &&  sign))
                            pc_src = PCSRC_BR;
                    end
                    default: state_n = S_HALT;
                endcase
            end
            S_MEM: begin
                sel_en = 1'b1;
                case (iclass)
                    IC_LW: state_n = S_WB;
                    IC_SW: begin
                        m_wr     = 1'b1;
                        pc_write = 1'b1;
                        state_n  = S_IF;
                    end
                    default: state_n = S_HALT;
                endcase
            end
            S_WB: begin
                sel_en    = 1'b1;
                reg_write = 1'b1;
                pc_write  = 1'b1;
                reg_dst   = ctrl.reg_dst;
                data_src  = (iclass == IC_LW);
                state_n   = S_IF;
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_HALT;
        endcase
    end

    // Reset gates every control output so nothing is written while rst is low
    assign PCWrite  = rst & pc_write;
    assign IRWrite  = rst & ir_write;
    assign Regwrite = rst & reg_write;
    assign mWR      = rst & m_wr;
    assign RegDst   = rst & reg_dst;
    assign datasrc  = rst & data_src;
    assign pcsrc    = rst ? pc_src : PCSRC_SEQ;
    assign ALUop    = (rst && sel_en) ? ctrl.alu_op : ALU_ADD;
    assign ALUsrcA  = rst & sel_en & ctrl.alu_src_a;
    assign ALUsrcB  = rst & sel_en & ctrl.alu_src_b;
    assign ExtSel   = rst & sel_en & ctrl.ext_sel;
    assign state    = state_q;
    assign halt     = halt_q;
    assign illegal  = illegal_q;
    assign instret  = instret_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port `rst`, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port `op`, input, 6 bits: opcode field from the instruction register.
REQ-004 SHALL have port `funct`, input, 6 bits: funct field from the instruction register.
REQ-005 SHALL have ports `zero` and `sign`, inputs, 1 bit each: ALU flags, valid in EXE.
REQ-006 SHALL have outputs `PCWrite`, `IRWrite`, `Regwrite` and `mWR`, 1 bit each: write enables.
REQ-007 SHALL have outputs `ALUsrcA`, `ALUsrcB`, `RegDst`, `ExtSel` and `datasrc`, 1 bit each: datapath mux selects.
REQ-008 SHALL have output `pcsrc`, 2 bits: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-009 SHALL have output `ALUop`, 4 bits: ALU operation code.
REQ-010 SHALL have output `state`, 3 bits: current FSM state, for debug.
REQ-011 SHALL have outputs `halt` and `illegal`, 1 bit each: sticky stop flags.
REQ-012 SHALL have output `instret`, 32 bits: count of retired instructions.

Function
REQ-013 SHALL implement the states IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to HALT.
REQ-014 SHALL assert IRWrite in IF only; IF always goes to ID.
REQ-015 SHALL route ID as follows: j goes to IF with PCWrite=1 and pcsrc=10; op 111111 goes to HALT with halt=1; an undecoded op/funct goes to HALT with illegal=1; every other instruction goes to EXE.
REQ-016 SHALL route EXE as follows: lw and sw go to MEM; R-type, addi, andi, ori and slti go to WB; beq, bne and bltz go to IF with PCWrite=1.
REQ-017 SHALL, for a branch in EXE, set pcsrc=01 when taken (beq: zero=1; bne: zero=0; bltz: sign=1) and pcsrc=00 otherwise.
REQ-018 SHALL, in MEM: for lw, go to WB; for sw, assert mWR=1 and PCWrite=1 with pcsrc=00, then go to IF.
REQ-019 SHALL, in WB, assert Regwrite=1 and PCWrite=1 with pcsrc=00, then go to IF; RegDst=1 for R-type, 0 otherwise; datasrc=1 for lw, 0 otherwise.
REQ-020 SHALL assert PCWrite exactly once per instruction, in its final state, so PC is constant during the instruction.
REQ-021 SHALL produce these instruction latencies: j = 2 cycles; branch = 3; R/I-ALU and sw = 4; lw = 5.
REQ-022 SHALL decode R-type (op 000000) funct as: 100000 add, 100010 sub, 100100 and, 100101 or, 000000 sll, 101010 slt.
REQ-023 SHALL decode I-type op as: addi 001000, andi 001100, ori 001101, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101, bltz 000001, j 000010.
REQ-024 SHALL encode ALUop as ADD=0, SUB=1, AND=2, OR=3, SLL=4, SLT=5 (signed); branches SHALL use SUB; lw and sw SHALL use ADD.
REQ-025 SHALL set ALUsrcA=1 for sll only, ALUsrcB=1 for I-ALU/lw/sw, and ExtSel=0 for andi and ori, 1 otherwise.
REQ-026 SHALL hold ALUop, ALUsrcA, ALUsrcB and ExtSel stable from ID through the final state of the instruction.
REQ-027 SHALL increment instret (mod 2^32, wrapping 0xFFFFFFFF to 0) on every cycle in which PCWrite=1.
REQ-028 SHALL make HALT absorbing: all enables 0, only reset exits.

Reset
REQ-029 SHALL, on rst=0 (asynchronous), force state=IF, all enables 0, all selects 0, ALUop=0, halt=0, illegal=0 and instret=0.
REQ-030 SHALL, when reset is asserted mid-instruction, abort the instruction with no register, memory or PC write.
REQ-031 SHALL, after reset deassertion, perform IF on the first rising edge.

Structure
REQ-032 SHALL place the opcode, funct, ALUop and state encodings in a shared package `mips_defs`.
REQ-033 SHALL use one combinational sub-module `inst_decode` (op/funct in, instruction class plus ALUop/ALUsrcA/ALUsrcB/ExtSel/RegDst out); the FSM and counter SHALL stay in the top level.

Verification
REQ-034 SHALL cover: add (op 000000, funct 100000) -> state 0,1,2,4,0; Regwrite=1 and RegDst=1 in cycle 4 only; instret +1.
REQ-035 SHALL cover: lw, then sw -> lw takes 5 cycles with datasrc=1 in WB; sw asserts mWR=1 for exactly 1 cycle in MEM and never asserts Regwrite.
REQ-036 SHALL cover: beq with zero=1, then zero=0 -> pcsrc=01, then 00, with PCWrite=1 in EXE each time; bltz with sign=1 -> pcsrc=01.
REQ-037 SHALL cover: j -> PCWrite=1 and pcsrc=10 in the ID cycle; total latency 2 cycles.
REQ-038 SHALL cover: op 111111 -> halt=1 and state=5 held for 100 cycles; op 011111 -> illegal=1; neither case writes anything.
REQ-039 SHALL cover: rst pulsed low during MEM of sw -> mWR stays 0, state=0 and instret=0 immediately (asynchronous).
